// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared types and helpers for the sequenced N-to-2^N decoder
// Purpose: FSM state encoding, output-width computation and the one-hot helper.
// Ports:   none (package).
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    // Largest select width the one-hot helper can produce; wider decoders need a wider helper.
    localparam int unsigned MAX_N     = 8;
    localparam int unsigned MAX_OUT_W = 32'd1 << MAX_N;

    // OUT_W = 2**n, written as a shift so the result stays unsigned.
    function automatic int unsigned out_w(input int unsigned n);
        return 32'd1 << n;
    endfunction

    // 1 << value, limited to the 2**n low bits; callers size-cast to their own OUT_W.
    function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned n, input int unsigned value);
        logic [MAX_OUT_W-1:0] mask;
        mask = (MAX_OUT_W'(1) << out_w(n)) - MAX_OUT_W'(1);
        return (MAX_OUT_W'(1) << value) & mask;
    endfunction

endpackage

// File: rtl/decoder_n2m_seq_dwell_timer.sv
// rtl/decoder_n2m_seq_dwell_timer.sv - loadable down-counter timing each SCAN position
// Purpose: holds the remaining dwell cycles of the current SCAN position.
// Ports:   clk, rst (async, active-high); i_clear (force 0, highest priority);
//          i_load/i_load_val (reload); i_dec (count down, saturates at 0);
//          o_zero (counter reads 0).
module dwell_timer #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic [DW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_zero
);

    logic [DW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - DW'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/decoder_n2m_seq.sv
// rtl/decoder_n2m_seq.sv - registered N-to-2^N one-hot decoder with handshake and SCAN mode
// Purpose: DECODE mode latches 1<<sel on each accepted transfer and holds it;
//          SCAN mode walks a single one through all outputs, dwell+1 cycles per position.
// Ports:   clk, rst (async, active-high); en (0 forces IDLE); mode (0 DECODE, 1 SCAN);
//          in_valid/in_ready/sel (select handshake, in_ready combinational);
//          dwell (extra cycles per SCAN position); out_valid/d/idx (registered one-hot
//          code and its index); wrap (pulse on the SCAN step from OUT_W-1 to 0).
module decoder_n2m_seq
    import decoder_pkg::*;
#(
    parameter  int unsigned N     = 3,
    parameter  int unsigned DW    = 8,
    localparam int unsigned OUT_W = out_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     sel,
    input  logic [DW-1:0]    dwell,
    output logic             out_valid,
    output logic [OUT_W-1:0] d,
    output logic [N-1:0]     idx,
    output logic             wrap
);

    state_t             r_state;
    logic [OUT_W-1:0]   r_d;
    logic [N-1:0]       r_idx;
    logic               r_out_valid;
    logic               r_wrap;

    state_t             w_state_nxt;
    logic [OUT_W-1:0]   w_d_nxt;
    logic [N-1:0]       w_idx_nxt;
    logic               w_valid_nxt;
    logic               w_wrap_nxt;
    logic               w_t_clear;
    logic               w_t_load;
    logic               w_t_dec;
    logic               w_t_zero;
    logic               w_in_ready;
    logic               w_accept;
    logic [OUT_W-1:0]   w_sel_onehot;
    logic [OUT_W-1:0]   w_first_onehot;

    assign w_in_ready     = en & ~mode;
    assign w_accept       = in_valid & w_in_ready;
    assign w_sel_onehot   = OUT_W'(onehot(N, 32'(sel)));
    assign w_first_onehot = OUT_W'(onehot(N, 32'd0));

    dwell_timer #(
        .DW (DW)
    ) u_dwell_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_t_clear),
        .i_load     (w_t_load),
        .i_load_val (dwell),
        .i_dec      (w_t_dec),
        .o_zero     (w_t_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_d         <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_d         <= w_d_nxt;
            r_idx       <= w_idx_nxt;
            r_out_valid <= w_valid_nxt;
            r_wrap      <= w_wrap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_d_nxt     = r_d;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_out_valid;
        w_wrap_nxt  = 1'b0;
        w_t_clear   = 1'b0;
        w_t_load    = 1'b0;
        w_t_dec     = 1'b0;

        if (!en) begin
            // Disable wins over every other event.
            w_state_nxt = IDLE;
            w_d_nxt     = '0;
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_t_clear   = 1'b1;
        end else begin
            unique case (r_state)
                IDLE, HOLD: begin
                    if (mode) begin
                        w_state_nxt = SCAN;
                        w_d_nxt     = w_first_onehot;
                        w_idx_nxt   = '0;
                        w_valid_nxt = 1'b1;
                        w_t_load    = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = HOLD;
                        w_d_nxt     = w_sel_onehot;
                        w_idx_nxt   = sel;
                        w_valid_nxt = 1'b1;
                    end
                end
                SCAN: begin
                    if (!mode) begin
                        // Leaving SCAN keeps the current position unless a transfer lands now.
                        w_state_nxt = HOLD;
                        w_valid_nxt = 1'b1;
                        w_t_clear   = 1'b1;
                        if (w_accept) begin
                            w_d_nxt   = w_sel_onehot;
                            w_idx_nxt = sel;
                        end
                    end else if (w_t_zero) begin
                        w_d_nxt    = {r_d[OUT_W-2:0], r_d[OUT_W-1]};
                        w_idx_nxt  = r_idx + N'(1);
                        w_wrap_nxt = &r_idx;
                        w_t_load   = 1'b1;
                    end else begin
                        w_t_dec = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_d_nxt     = '0;
                    w_idx_nxt   = '0;
                    w_valid_nxt = 1'b0;
                    w_t_clear   = 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign d         = r_d;
    assign idx       = r_idx;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_decoder_n2m_seq.sv
// tb/tb_decoder_n2m_seq.sv - scoreboard bench for decoder_n2m_seq
module tb_decoder_n2m_seq;

    localparam int N     = 3;
    localparam int DW    = 8;
    localparam int OUT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             en = 1'b0, mode = 1'b0, in_valid = 1'b0;
    logic [N-1:0]     sel = '0;
    logic [DW-1:0]    dwell = '0;
    logic             in_ready, out_valid, wrap;
    logic [OUT_W-1:0] d;
    logic [N-1:0]     idx;

    logic             en4 = 1'b0, mode4 = 1'b0, iv4 = 1'b0;
    logic [3:0]       sel4 = '0;
    logic [DW-1:0]    dwell4 = '0;
    logic             rdy4, ov4, wrap4;
    logic [15:0]      d4;
    logic [3:0]       idx4;

    decoder_n2m_seq #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .dwell(dwell), .out_valid(out_valid),
        .d(d), .idx(idx), .wrap(wrap)
    );

    decoder_n2m_seq #(.N(4), .DW(DW)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .mode(mode4), .in_valid(iv4),
        .in_ready(rdy4), .sel(sel4), .dwell(dwell4), .out_valid(ov4),
        .d(d4), .idx(idx4), .wrap(wrap4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    typedef struct {
        logic [OUT_W-1:0] d;
        int               pos;
        logic             v;
        logic             w;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: position of the single lit output, whether it is lit,
    // whether the walking one is running, and cycles left at the current position.
    bit m_valid, m_scan, m_wrap;
    int m_pos, m_rem;

    task automatic model_reset();
        m_valid = 0; m_scan = 0; m_wrap = 0; m_pos = 0; m_rem = 0;
    endtask

    task automatic model_update(input bit t_en, input bit t_mode, input bit t_iv, input int t_sel, input int t_dw);
        m_wrap = 0;
        if (!t_en) begin
            m_valid = 0; m_pos = 0; m_scan = 0;
        end else if (t_mode) begin
            if (!m_scan) begin
                m_scan = 1; m_pos = 0; m_valid = 1; m_rem = t_dw;
            end else if (m_rem == 0) begin
                m_pos  = (m_pos + 1) % OUT_W;
                m_wrap = (m_pos == 0);
                m_rem  = t_dw;
            end else begin
                m_rem--;
            end
        end else begin
            m_scan = 0;
            if (t_iv) begin
                m_pos = t_sel; m_valid = 1;
            end
        end
    endtask

    // One clock of stimulus: drive at the falling edge, check the combinational ready,
    // and queue what the outputs must show after the next rising edge.
    task automatic step(input bit t_en, input bit t_mode, input bit t_iv, input int t_sel, input int t_dw);
        exp_t e;
        @(negedge clk);
        en = t_en; mode = t_mode; in_valid = t_iv;
        sel = N'(t_sel); dwell = DW'(t_dw);
        #1;
        check("in_ready", 32'(in_ready), 32'(t_en & ~t_mode));
        model_update(t_en, t_mode, t_iv, t_sel, t_dw);
        e.v   = m_valid;
        e.pos = m_valid ? m_pos : 0;
        e.d   = m_valid ? (OUT_W'(1) << m_pos) : '0;
        e.w   = m_wrap;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("d", 32'(d), 32'(e.d));
                check("idx", 32'(idx), 32'(e.pos));
                check("out_valid", 32'(out_valid), 32'(e.v));
                check("wrap", 32'(wrap), 32'(e.w));
            end
        end
    end

    initial begin : driver
        bit r_mode;
        model_reset();
        repeat (2) @(negedge clk);
        en = 1'b1; mode = 1'b0;
        #1;
        check("reset_d", 32'(d), 32'h0);
        check("reset_idx", 32'(idx), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_wrap", 32'(wrap), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;

        // Wider instance: top select value and one interior value.
        @(negedge clk);
        en4 = 1'b1; iv4 = 1'b1; sel4 = 4'd15;
        @(negedge clk);
        check("n4_d_sel15", 32'(d4), 32'h8000);
        check("n4_idx_sel15", 32'(idx4), 32'd15);
        check("n4_out_valid", 32'(ov4), 32'h1);
        sel4 = 4'd9;
        @(negedge clk);
        check("n4_d_sel9", 32'(d4), 32'h0200);
        en4 = 1'b0; iv4 = 1'b0;

        // Decode sweep, back to back.
        for (int s = 0; s < OUT_W; s++) step(1, 0, 1, s, 0);
        // Accept 5, then hold.
        step(1, 0, 1, 5, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, $urandom_range(0, 7), 0);
        // Scan with dwell 2 for two full periods plus a little, then dwell 0.
        for (int i = 0; i < 52; i++) step(1, 1, $urandom_range(0, 1), $urandom_range(0, 7), 2);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0);
        // Mode switch at idx 3 without and with a transfer.
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        step(1, 0, 1, 6, 0);
        // Enable drop at d=0x10, then restart the scan.
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1);

        // Randomized traffic; mode changes rarely so scans run long enough to wrap.
        r_mode = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) r_mode = ~r_mode;
            step($urandom_range(0, 19) != 0, r_mode, $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of a scan.
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_d", 32'(d), 32'h0);
        check("async_rst_idx", 32'(idx), 32'h0);
        check("async_rst_out_valid", 32'(out_valid), 32'h0);
        check("async_rst_wrap", 32'(wrap), 32'h0);
        en = 1'b1; mode = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 1, $urandom_range(0, 7), 0);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
